// File: rtl/ysyx_22050598_pipe_skid_reg.sv
// Pipeline stage register: two-entry skid buffer (SKID_EN=1) or single-entry
// register (SKID_EN=0), with a saturating count of stalled output cycles.
module ysyx_22050598_pipe_skid_reg #(
    parameter int DW      = 71,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Reject parameter values the datapath cannot represent
    if (DW < 1 || CNT_W < 1 || SKID_EN < 0 || SKID_EN > 1) begin : g_bad_param
        $error("ysyx_22050598_pipe_skid_reg: unsupported DW/SKID_EN/CNT_W");
    end

    if (SKID_EN == 1) begin : g_skid
        typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_FULL  = 2'd1,
            ST_SKID  = 2'd2
        } state_e;

        state_e          state_q, state_d;
        logic [DW-1:0]   main_q, main_d;
        logic [DW-1:0]   skid_q, skid_d;
        logic            in_ready_q, in_ready_d;
        logic            in_xfer;
        logic            out_xfer;

        assign in_xfer  = in_valid & in_ready_q & ~flush;
        assign out_xfer = (state_q != ST_EMPTY) & out_ready;

        // State, payload and ready registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_EMPTY;
                main_q     <= '0;
                skid_q     <= '0;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        // Next-state: flush always empties the stage
        always_comb begin
            state_d = state_q;
            if (flush) begin
                state_d = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: if (in_xfer) state_d = ST_FULL;
                    ST_FULL: begin
                        if (in_xfer && !out_xfer)      state_d = ST_SKID;
                        else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
                    end
                    ST_SKID:  if (out_xfer) state_d = ST_FULL;
                    default:  state_d = ST_EMPTY;
                endcase
            end
        end

        // Payload steering and registered ready (ready is a pure decode of next state)
        always_comb begin
            main_d     = main_q;
            skid_d     = skid_q;
            in_ready_d = (state_d != ST_SKID);
            case (state_q)
                ST_EMPTY: if (in_xfer) main_d = in_data;
                ST_FULL: begin
                    if (in_xfer && out_xfer) main_d = in_data;
                    else if (in_xfer)        skid_d = in_data;
                end
                ST_SKID:  if (out_xfer) main_d = skid_q;
                default: ;
            endcase
        end

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != ST_EMPTY);
        assign out_data  = main_q;
        assign occupancy = (state_q == ST_SKID) ? 2'd2 :
                           (state_q == ST_FULL) ? 2'd1 : 2'd0;
    end else begin : g_reg
        logic            valid_q, valid_d;
        logic [DW-1:0]   main_q, main_d;
        logic            in_xfer;
        logic            out_xfer;

        assign in_ready = ~valid_q | out_ready;
        assign in_xfer  = in_valid & in_ready & ~flush;
        assign out_xfer = valid_q & out_ready;

        // Single entry register
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        // Load on accept, drain on delivery, flush discards
        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (in_xfer) begin
                valid_d = 1'b1;
                main_d  = in_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign occupancy = {1'b0, valid_q};
    end

    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles where the head is offered but not taken
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Stall counter register; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;

endmodule

// File: doc/ysyx_22050598_pipe_skid_reg.md
YSYX_22050598_PIPE_SKID_REG -- requirements
Module: ysyx_22050598_pipe_skid_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter DW, default 71, SHALL set the payload width in bits; the default covers rd_data(64) + rd_en(1) + rd_idx(5) + ebreak(1).
REQ-003 Parameter SKID_EN, default 1, SHALL select the mode: 1 = two-entry skid buffer, 0 = single-entry register.
REQ-004 Parameter CNT_W, default 32, SHALL set the width of the stall counter.
REQ-005 The ports SHALL be as follows (name  direction  width  meaning):
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all held entries and any input offered this cycle
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept this cycle
- in_data  input  DW  upstream payload
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DW  head payload
- occupancy  output  2  number of held entries (0..2)
- stall_cnt  output  CNT_W  cycles in which out_valid=1 and out_ready=0

Function
REQ-006 An input transfer SHALL occur when in_valid & in_ready & ~flush; an output transfer SHALL occur when out_valid & out_ready.
REQ-007 Latency SHALL be one cycle: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N; there SHALL be no combinational path from in_data to out_data.
REQ-008 Payloads SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-009 With SKID_EN=1, the block SHALL hold three states: EMPTY (occupancy 0), FULL (main entry valid, occupancy 1), SKID (main and skid entries valid, occupancy 2).
REQ-010 With SKID_EN=1, in_ready SHALL be a register output, equal to 1 exactly when the state is not SKID; no combinational path from out_ready to in_ready SHALL exist.
REQ-011 From EMPTY, an input transfer SHALL load main and move to FULL; otherwise the block SHALL stay in EMPTY.
REQ-012 From FULL with both an input and an output transfer, main SHALL load in_data and the block SHALL stay in FULL.
REQ-013 From FULL with an output transfer only, the block SHALL move to EMPTY.
REQ-014 From FULL with an input transfer only, skid SHALL load in_data and the block SHALL move to SKID.
REQ-015 From FULL with neither transfer, the block SHALL hold.
REQ-016 From SKID with an output transfer, main SHALL load skid and the block SHALL move to FULL; otherwise the block SHALL hold.
REQ-017 With SKID_EN=0, in_ready SHALL equal ~out_valid | out_ready (combinational), the block SHALL have one entry, and occupancy SHALL never exceed 1; no skid register SHALL be synthesised.
REQ-018 Flush SHALL force the state to EMPTY at the next edge, discarding the held entries and that cycle's input; an output transfer in the flush cycle SHALL still count as delivered.
REQ-019 Flush SHALL NOT clear payload registers or stall_cnt; out_data is don't-care while out_valid=0.
REQ-020 out_valid SHALL equal (occupancy != 0).
REQ-021 stall_cnt SHALL increment by 1 in each cycle with out_valid & ~out_ready.
REQ-022 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 Unsupported parameter values (DW<1, SKID_EN not in {0,1}) SHALL fail elaboration.

Reset
REQ-024 When rst=1 at an edge, the next state SHALL be EMPTY, main and skid SHALL be 0, and stall_cnt SHALL be 0, regardless of flush or handshakes.
REQ-025 After reset, the outputs SHALL be out_valid=0, out_data=0, occupancy=0, stall_cnt=0, and in_ready=1.
REQ-026 Reset asserted mid-operation, including in SKID, SHALL discard all entries within one edge; no transfer SHALL be reported in the reset cycle.

Verification
REQ-027 Stream test: SKID_EN=1, out_ready=1, feed 0x1..0x8 on consecutive cycles -> out_data is 0x1..0x8 one cycle delayed, in_ready stays 1, and stall_cnt=0.
REQ-028 Backpressure test: SKID_EN=1, accept 0xA, drop out_ready, offer 0xB -> occupancy=2, in_ready=0, and 0xC is held off; raise out_ready -> 0xA, 0xB, 0xC emerge in order with no loss.
REQ-029 Flush test: in SKID holding 0x11 and 0x22, pulse flush with in_valid=1 and data 0x33 -> next cycle occupancy=0, out_valid=0, and 0x33 never appears.
REQ-030 Mode test: SKID_EN=0, out_valid=1, out_ready=0 -> in_ready=0 combinationally; set out_ready=1 with in_valid=1 and data 0x5 -> 0x5 replaces the head in the same edge.
REQ-031 Saturation test: CNT_W=4 with 20 stalled cycles -> stall_cnt=15 and it holds there; then assert rst -> stall_cnt=0.
REQ-032 Reset-priority test: rst=1 and flush=1 together while in FULL with data 0x7 -> out_data=0 and occupancy=0 next cycle.
